// File: rtl/control_pipe.sv
// control_pipe: registered instruction decoder with valid/ready handshake.
// Decodes one instruction per cycle into a registered control bundle and
// sequences multi-cycle mul/div, halt/resume and error trapping.
module control_pipe #(
    parameter int INSTR_W       = 16,
    parameter int MULDIV_CYCLES = 4,
    parameter bit ERR_HALTS     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               flush,
    input  logic               resume,
    output logic               ctrl_valid,
    output logic               w2_addr_src,
    output logic               w2_en,
    output logic               write_back,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic               alu_op,
    output logic               alu_op2_src,
    output logic               memory_read,
    output logic               memory_write,
    output logic               byte_select,
    output logic               jump,
    output logic               branch,
    output logic               busy,
    output logic               lock,
    output logic               err
);

    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    localparam logic [11:0] W2A  = 12'h800;
    localparam logic [11:0] W2E  = 12'h400;
    localparam logic [11:0] WB   = 12'h200;
    localparam logic [11:0] M2R  = 12'h100;
    localparam logic [11:0] ASRC = 12'h080;
    localparam logic [11:0] AOP  = 12'h040;
    localparam logic [11:0] AOP2 = 12'h020;
    localparam logic [11:0] MRD  = 12'h010;
    localparam logic [11:0] MWR  = 12'h008;
    localparam logic [11:0] BSEL = 12'h004;
    localparam logic [11:0] JMP  = 12'h002;
    localparam logic [11:0] BR   = 12'h001;

    typedef enum logic [1:0] {RUN, MULTI, HALT, ERROR} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic             ctrlValid_q;
    logic             busy_q;
    logic             lock_q;
    logic             err_q;
    logic [11:0]      bundle_q;

    logic [3:0]       opcode;
    logic [3:0]       func;
    logic [11:0]      decBundle;
    logic             decMulDiv;
    logic             decHalt;
    logic             decBad;
    logic             accept;
    logic             unusedMidBits;

    assign opcode        = instr[INSTR_W-1 -: 4];
    assign func          = instr[3:0];
    assign unusedMidBits = ^instr[INSTR_W-5:4];

    assign instr_ready = (state_q == RUN) && !rst;
    assign accept      = instr_valid && instr_ready && !flush;

    // Combinational opcode/function decode into the bundle that gets registered on accept.
    always_comb begin
        decBundle = '0;
        decMulDiv = 1'b0;
        decHalt   = 1'b0;
        decBad    = 1'b0;
        casez (opcode)
            4'b1111: begin
                decBundle = WB | AOP;
                if (func[3:1] == 3'b010) begin
                    decBundle = WB | AOP | W2A | W2E;
                    decMulDiv = 1'b1;
                end else if (func == 4'b1000) begin
                    decBundle = WB | AOP | W2A | W2E;
                end
            end
            4'b100?: decBundle = WB | ASRC | AOP;
            4'b1010: decBundle = WB | M2R | ASRC | AOP | MRD | BSEL;
            4'b1011: decBundle = ASRC | AOP | MWR | BSEL;
            4'b1100: decBundle = WB | M2R | ASRC | AOP | MRD;
            4'b1101: decBundle = ASRC | AOP | MWR;
            4'b010?: decBundle = AOP2 | AOP | BR;
            4'b0110: decBundle = AOP2 | AOP | BR;
            4'b0001: decBundle = JMP;
            4'b0000: decHalt   = 1'b1;
            default: decBad    = 1'b1;
        endcase
    end

    // Sequencer: issues the registered bundle and walks RUN/MULTI/HALT/ERROR with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            count_q     <= '0;
            ctrlValid_q <= 1'b0;
            bundle_q    <= '0;
            busy_q      <= 1'b0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ctrlValid_q <= 1'b0;
            bundle_q    <= '0;
            err_q       <= (state_q == ERROR);
            case (state_q)
                RUN: begin
                    if (accept) begin
                        if (decBad) begin
                            err_q <= 1'b1;
                            if (ERR_HALTS) begin
                                state_q <= ERROR;
                                lock_q  <= 1'b1;
                            end else begin
                                ctrlValid_q <= 1'b1;
                            end
                        end else begin
                            ctrlValid_q <= 1'b1;
                            bundle_q    <= decBundle;
                            if (decHalt) begin
                                state_q <= HALT;
                                lock_q  <= 1'b1;
                            end else if (decMulDiv && (MULDIV_CYCLES > 1)) begin
                                state_q <= MULTI;
                                busy_q  <= 1'b1;
                                count_q <= CNT_LOAD;
                            end
                        end
                    end
                end
                MULTI: begin
                    if (flush) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_q <= RUN;
                        lock_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ERROR;
                end
            endcase
        end
    end

    assign ctrl_valid   = ctrlValid_q;
    assign w2_addr_src  = bundle_q[11];
    assign w2_en        = bundle_q[10];
    assign write_back   = bundle_q[9];
    assign mem_to_reg   = bundle_q[8];
    assign alu_src      = bundle_q[7];
    assign alu_op       = bundle_q[6];
    assign alu_op2_src  = bundle_q[5];
    assign memory_read  = bundle_q[4];
    assign memory_write = bundle_q[3];
    assign byte_select  = bundle_q[2];
    assign jump         = bundle_q[1];
    assign branch       = bundle_q[0];
    assign busy         = busy_q;
    assign lock         = lock_q;
    assign err          = err_q;

endmodule
